// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/stop/lap/clear sequencing over a cascaded BCD digit
// chain, with a freezable display copy and sticky overflow.
module stopwatch_ctrl #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick_i,
    input  logic                    start_stop_i,
    input  logic                    lap_i,
    input  logic                    clear_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic [4*NUM_DIGITS-1:0] disp_o,
    output logic                    running_o,
    output logic                    lap_active_o,
    output logic                    overflow_o
);

    localparam int unsigned W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RUN_LAP = 2'd2,
        S_STOP    = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   disp_q, disp_d;
    logic           overflow_q, overflow_d;
    logic           running_q, running_d;
    logic           lap_active_q, lap_active_d;

    logic [W-1:0]   count_inc;
    logic           carry;
    logic [3:0]     dig;
    logic           inc_en;
    logic           zero_cnt;

    // Ripple a +1 through the BCD digits; carry out of the top means all-9s wrapped.
    always_comb begin
        count_inc = '0;
        carry     = 1'b1;
        dig       = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            dig = count_q[4*k +: 4];
            if (carry) begin
                if (dig == 4'd9) begin
                    dig = 4'd0;
                end else begin
                    dig   = dig + 4'd1;
                    carry = 1'b0;
                end
            end
            count_inc[4*k +: 4] = dig;
        end
    end

    // Next-state, counter, display and flag computation.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        disp_d       = disp_q;
        overflow_d   = overflow_q;
        running_d    = 1'b0;
        lap_active_d = 1'b0;

        if (clear_i) begin
            state_d = S_IDLE;
        end else if (start_stop_i) begin
            unique case (state_q)
                S_IDLE:    state_d = S_RUN;
                S_RUN:     state_d = S_STOP;
                S_RUN_LAP: state_d = S_STOP;
                S_STOP:    state_d = S_RUN;
                default:   state_d = S_IDLE;
            endcase
        end else if (lap_i) begin
            unique case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_RUN:     state_d = S_RUN_LAP;
                S_RUN_LAP: state_d = S_RUN;
                S_STOP:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end

        // Counting is judged on the current state so exit-cycle ticks still land.
        inc_en   = ((state_q == S_RUN) || (state_q == S_RUN_LAP)) && tick_i && !clear_i;
        zero_cnt = clear_i || ((state_q == S_STOP) && !start_stop_i && lap_i);

        if (zero_cnt) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (inc_en) begin
            count_d = count_inc;
            if (carry) begin
                overflow_d = 1'b1;
            end
        end

        // disp_q equals count_q while running unfrozen, so holding it captures the pre-edge count.
        if (state_d != S_RUN_LAP) begin
            disp_d = count_d;
        end

        running_d    = (state_d == S_RUN) || (state_d == S_RUN_LAP);
        lap_active_d = (state_d == S_RUN_LAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            disp_q       <= '0;
            overflow_q   <= 1'b0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            disp_q       <= disp_d;
            overflow_q   <= overflow_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign count_o      = count_q;
    assign disp_o       = disp_q;
    assign running_o    = running_q;
    assign lap_active_o = lap_active_q;
    assign overflow_o   = overflow_q;

endmodule
